// File: rtl/mem_stage_if.sv
// Word-addressed req/ack data bus between mem_stage (master) and memory (slave).
interface mem_stage_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
        input  bus_rdata_i, bus_ack_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
        output bus_rdata_i, bus_ack_i
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage with MEM/WB pipeline register over a req/ack data bus.
// Optional bus-timeout abort enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [31:0]      result_i,
    input  logic [31:0]      MemData_i,
    input  logic             MemToReg_i,
    input  logic             MemWrite_i,
    input  logic             ALUToReg_i,
    input  logic [4:0]       WriteRegDst_i,
    output logic             stall_o,
    mem_stage_if.master      bus,
    output logic [31:0]      wb_data_o,
    output logic             RegWrite_o,
    output logic [4:0]       WriteRegDst_o,
    output logic             bus_err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state, state_d;
    logic        mem_op;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        reg_write_q, reg_write_d;
    logic [4:0]  dst_q, dst_d;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    // A load-and-store (both flags set) is illegal and degrades to a store via we = MemWrite_i.
    assign mem_op  = valid_i & (MemToReg_i | MemWrite_i);
    assign stall_o = ~rst & (((state == IDLE) & mem_op) | (state == ACCESS));

    assign bus.bus_req_o   = req_q;
    assign bus.bus_we_o    = we_q;
    assign bus.bus_addr_o  = addr_q;
    assign bus.bus_wdata_o = wdata_q;
    assign wb_data_o       = wb_data_q;
    assign RegWrite_o      = reg_write_q;
    assign WriteRegDst_o   = dst_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latch).
        state_d     = state;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wb_data_d   = wb_data_q;
        reg_write_d = 1'b0;
        dst_d       = dst_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        unique case (state)
            IDLE: begin
                if (mem_op) begin
                    addr_d  = result_i;
                    wdata_d = MemData_i;
                    we_d    = MemWrite_i;
                    req_d   = 1'b1;
                    state_d = ACCESS;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end else begin
                    wb_data_d   = result_i;
                    reg_write_d = valid_i & ALUToReg_i;
                    dst_d       = WriteRegDst_i;
                end
            end
            ACCESS: begin
                if (bus.bus_ack_i) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    dst_d   = WriteRegDst_i;
                    if (we_q) begin
                        wb_data_d = addr_q;
                    end else begin
                        wb_data_d   = bus.bus_rdata_i;
                        reg_write_d = 1'b1;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 8'd1;
                    // Abort on the TIMEOUT-th unacknowledged cycle; ack has priority above.
                    if (cnt_d == TIMEOUT_CNT) begin
                        req_d   = 1'b0;
                        state_d = DONE;
                        err_d   = 1'b1;
                        if (!we_q) begin
                            wb_data_d   = ERR_DATA;
                            reg_write_d = 1'b1;
                            dst_d       = WriteRegDst_i;
                        end
                    end
                end
`endif
            end
            DONE: begin
                // Upstream advances this cycle; the next instruction is evaluated in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wb_data_q   <= 32'd0;
            reg_write_q <= 1'b0;
            dst_q       <= 5'd0;
        end else begin
            state       <= state_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wb_data_q   <= wb_data_d;
            reg_write_q <= reg_write_d;
            dst_q       <= dst_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus_err_o = err_q;
`else
    assign bus_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; covers the timeout abort when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic [31:0] result_i = 32'd0;
    logic [31:0] MemData_i = 32'd0;
    logic        MemToReg_i = 1'b0;
    logic        MemWrite_i = 1'b0;
    logic        ALUToReg_i = 1'b0;
    logic [4:0]  WriteRegDst_i = 5'd0;
    logic        stall_o;
    logic [31:0] wb_data_o;
    logic        RegWrite_o;
    logic [4:0]  WriteRegDst_o;
    logic        bus_err_o;

    int compared   = 0;
    int mismatched = 0;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .result_i      (result_i),
        .MemData_i     (MemData_i),
        .MemToReg_i    (MemToReg_i),
        .MemWrite_i    (MemWrite_i),
        .ALUToReg_i    (ALUToReg_i),
        .WriteRegDst_i (WriteRegDst_i),
        .stall_o       (stall_o),
        .bus           (bus.master),
        .wb_data_o     (wb_data_o),
        .RegWrite_o    (RegWrite_o),
        .WriteRegDst_o (WriteRegDst_o),
        .bus_err_o     (bus_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [31:0] data,
                         input logic m2r, input logic mw, input logic a2r, input logic [4:0] dst);
        valid_i       = v;
        result_i      = res;
        MemData_i     = data;
        MemToReg_i    = m2r;
        MemWrite_i    = mw;
        ALUToReg_i    = a2r;
        WriteRegDst_i = dst;
    endtask

    task automatic bubble();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    // Advance to the middle of the next cycle so registered outputs have settled.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    initial begin
        bus.bus_ack_i   = 1'b0;
        bus.bus_rdata_i = 32'd0;
        bubble();
        repeat (2) next_cycle();
        #1;
        check("rst_req",   32'(bus.bus_req_o), 32'd0);
        check("rst_we",    32'(bus.bus_we_o), 32'd0);
        check("rst_addr",  bus.bus_addr_o, 32'd0);
        check("rst_wdata", bus.bus_wdata_o, 32'd0);
        check("rst_wb",    wb_data_o, 32'd0);
        check("rst_rw",    32'(RegWrite_o), 32'd0);
        check("rst_dst",   32'(WriteRegDst_o), 32'd0);
        check("rst_err",   32'(bus_err_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        next_cycle();
        rst = 1'b0;

        // Back-to-back ALU ops
        next_cycle();
        drive(1'b1, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3);
        #1 check("alu0_stall", 32'(stall_o), 32'd0);
        next_cycle();
        drive(1'b1, 32'd9, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4);
        #1;
        check("alu1_wb",    wb_data_o, 32'd5);
        check("alu1_rw",    32'(RegWrite_o), 32'd1);
        check("alu1_dst",   32'(WriteRegDst_o), 32'd3);
        check("alu1_stall", 32'(stall_o), 32'd0);
        next_cycle();
        bubble();
        #1;
        check("alu2_wb",  wb_data_o, 32'd9);
        check("alu2_rw",  32'(RegWrite_o), 32'd1);
        check("alu2_dst", 32'(WriteRegDst_o), 32'd4);
        // Ack outside ACCESS must be ignored
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = 32'h5555_5555;
        next_cycle();
        bus.bus_ack_i = 1'b0;
        #1;
        check("idle_ack_rw",  32'(RegWrite_o), 32'd0);
        check("idle_ack_req", 32'(bus.bus_req_o), 32'd0);

        // Load 0x40, acked in the first ACCESS cycle, then an ALU op
        next_cycle();
        drive(1'b1, 32'h40, 32'd0, 1'b1, 1'b0, 1'b0, 5'd7);
        #1;
        check("ld0_stall", 32'(stall_o), 32'd1);
        check("ld0_req",   32'(bus.bus_req_o), 32'd0);
        next_cycle();
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = 32'h1234;
        #1;
        check("ld1_req",   32'(bus.bus_req_o), 32'd1);
        check("ld1_addr",  bus.bus_addr_o, 32'h40);
        check("ld1_we",    32'(bus.bus_we_o), 32'd0);
        check("ld1_stall", 32'(stall_o), 32'd1);
        check("ld1_rw",    32'(RegWrite_o), 32'd0);
        next_cycle();
        bus.bus_ack_i   = 1'b0;
        bus.bus_rdata_i = 32'd0;
        #1;
        check("ld2_wb",    wb_data_o, 32'h1234);
        check("ld2_rw",    32'(RegWrite_o), 32'd1);
        check("ld2_dst",   32'(WriteRegDst_o), 32'd7);
        check("ld2_stall", 32'(stall_o), 32'd0);
        check("ld2_req",   32'(bus.bus_req_o), 32'd0);
        next_cycle();
        drive(1'b1, 32'd7, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5);
        #1;
        check("ld3_rw",    32'(RegWrite_o), 32'd0);
        check("ld3_stall", 32'(stall_o), 32'd0);
        next_cycle();
        bubble();
        #1;
        check("ld4_wb",  wb_data_o, 32'd7);
        check("ld4_rw",  32'(RegWrite_o), 32'd1);
        check("ld4_dst", 32'(WriteRegDst_o), 32'd5);

        // Store 0x10 <- 0xAA, acked after three wait cycles
        next_cycle();
        drive(1'b1, 32'h10, 32'hAA, 1'b0, 1'b1, 1'b0, 5'd9);
        #1 check("st0_stall", 32'(stall_o), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            bus.bus_ack_i = (i == 4);
            #1;
            check($sformatf("st%0d_req", i),   32'(bus.bus_req_o), 32'd1);
            check($sformatf("st%0d_we", i),    32'(bus.bus_we_o), 32'd1);
            check($sformatf("st%0d_wdata", i), bus.bus_wdata_o, 32'hAA);
            check($sformatf("st%0d_addr", i),  bus.bus_addr_o, 32'h10);
            check($sformatf("st%0d_stall", i), 32'(stall_o), 32'd1);
            check($sformatf("st%0d_rw", i),    32'(RegWrite_o), 32'd0);
        end
        next_cycle();
        bus.bus_ack_i = 1'b0;
        #1;
        check("st5_stall", 32'(stall_o), 32'd0);
        check("st5_rw",    32'(RegWrite_o), 32'd0);
        check("st5_req",   32'(bus.bus_req_o), 32'd0);
        check("st5_wb",    wb_data_o, 32'h10);
        next_cycle();
        bubble();
        #1 check("st6_rw", 32'(RegWrite_o), 32'd0);

        // Both load and store flags set behaves as a store
        next_cycle();
        drive(1'b1, 32'h20, 32'h33, 1'b1, 1'b1, 1'b1, 5'd6);
        next_cycle();
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = 32'h7777;
        #1 check("ls_we", 32'(bus.bus_we_o), 32'd1);
        next_cycle();
        bus.bus_ack_i = 1'b0;
        #1 check("ls_rw", 32'(RegWrite_o), 32'd0);
        next_cycle();
        bubble();

        // Reset asserted in the middle of an access
        next_cycle();
        drive(1'b1, 32'h50, 32'd0, 1'b1, 1'b0, 1'b0, 5'd8);
        next_cycle();
        #1 check("mr_req_pre", 32'(bus.bus_req_o), 32'd1);
        rst = 1'b1;
        #1;
        check("mr_req",   32'(bus.bus_req_o), 32'd0);
        check("mr_stall", 32'(stall_o), 32'd0);
        check("mr_rw",    32'(RegWrite_o), 32'd0);
        bus.bus_ack_i   = 1'b1;
        bus.bus_rdata_i = 32'h9999;
        bubble();
        next_cycle();
        rst           = 1'b0;
        next_cycle();
        bus.bus_ack_i = 1'b0;
        #1;
        check("mr_post_rw",    32'(RegWrite_o), 32'd0);
        check("mr_post_req",   32'(bus.bus_req_o), 32'd0);
        check("mr_post_stall", 32'(stall_o), 32'd0);

`ifdef MEM_TIMEOUT_EN
        // Load with no ack aborts after four ACCESS cycles
        next_cycle();
        drive(1'b1, 32'h60, 32'd0, 1'b1, 1'b0, 1'b0, 5'd2);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            #1;
            check($sformatf("to%0d_req", i), 32'(bus.bus_req_o), 32'd1);
            check($sformatf("to%0d_err", i), 32'(bus_err_o), 32'd0);
        end
        next_cycle();
        #1;
        check("to5_req",   32'(bus.bus_req_o), 32'd0);
        check("to5_err",   32'(bus_err_o), 32'd1);
        check("to5_wb",    wb_data_o, 32'hDEADBEEF);
        check("to5_rw",    32'(RegWrite_o), 32'd1);
        check("to5_dst",   32'(WriteRegDst_o), 32'd2);
        check("to5_stall", 32'(stall_o), 32'd0);
        next_cycle();
        bubble();
        #1;
        check("to6_err", 32'(bus_err_o), 32'd1);
        check("to6_rw",  32'(RegWrite_o), 32'd0);
        repeat (3) next_cycle();
        #1 check("to9_err", 32'(bus_err_o), 32'd1);
`else
        check("noto_err", 32'(bus_err_o), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage plus MEM/WB pipeline register, directly downstream of the execute stage.
- Consumes the ALU result, store data and control signals.
- Performs loads and stores over a req/ack data bus and stalls the upstream pipeline while an access is outstanding.
- Presents a registered write-back word, destination register and write enable to the WB stage.

Parameters:
TIMEOUT, 16, max ACCESS cycles without bus_ack_i before abort (used only with MEM_TIMEOUT_EN)
ERR_DATA, 32'hDEADBEEF, write-back value substituted on an aborted load (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  instruction present from EX (0 = bubble)
- result_i  in  32  ALU result; word address for load/store
- MemData_i  in  32  store data (EX reg2)
- MemToReg_i  in  1  instruction is a load
- MemWrite_i  in  1  instruction is a store
- ALUToReg_i  in  1  ALU result is written back
- WriteRegDst_i  in  5  destination register
- stall_o  out  1  hold EX and earlier stages; inputs must stay stable while high
- bus_req_o  out  1  bus request, registered
- bus_we_o  out  1  1 = write
- bus_addr_o  out  32  word address
- bus_wdata_o  out  32  write data
- bus_rdata_i  in  32  read data, valid with bus_ack_i
- bus_ack_i  in  1  access complete
- wb_data_o  out  32  registered write-back data
- RegWrite_o  out  1  registered write enable to WB
- WriteRegDst_o  out  5  registered destination
- bus_err_o  out  1  sticky bus-timeout flag

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o = 0.
  - wb_data_o, RegWrite_o, WriteRegDst_o = 0; bus_err_o = 0.
  - Reset mid-access drops bus_req_o immediately. Any in-flight ack is ignored after reset.
- mem_op = valid_i & (MemToReg_i | MemWrite_i). Both flags set is treated as a load-and-store: illegal, so treated as a store.
- stall_o (combinational) = (state==IDLE & mem_op) | (state==ACCESS).
- State IDLE:
  - If mem_op: latch bus_addr_o=result_i, bus_wdata_o=MemData_i, bus_we_o=MemWrite_i; set bus_req_o=1; go to ACCESS. The MEM/WB register loads a bubble (RegWrite_o=0).
  - Else (ALU op or bubble): MEM/WB loads wb_data_o=result_i, RegWrite_o=valid_i & ALUToReg_i, WriteRegDst_o=WriteRegDst_i. Single-cycle latency.
- State ACCESS:
  - bus_req_o held high; address/data/we stable.
  - On bus_ack_i: bus_req_o<=0; go to DONE; MEM/WB loads:
    - load: wb_data_o=bus_rdata_i, RegWrite_o=1;
    - store: wb_data_o=bus_addr_o, RegWrite_o=0.
    - WriteRegDst_o=WriteRegDst_i.
  - Without ack: MEM/WB loads a bubble each cycle.
- State DONE:
  - stall_o=0, so upstream advances this cycle.
  - MEM/WB loads a bubble, so the write is not duplicated.
  - Unconditionally go to IDLE. The next instruction is evaluated in IDLE, adding one bubble after every memory op.
- Minimum load timing (ack in first ACCESS cycle):
  - op enters cycle 0;
  - req high cycle 1;
  - wb_data_o valid cycle 2;
  - stall_o high cycles 0–1.
- bus_ack_i outside ACCESS is ignored. bus_rdata_i is sampled only with ack.
- No address arithmetic: the address is word-granular, passed through unchanged.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to ACCESS and increments per ACCESS cycle without ack.
  - When it reaches TIMEOUT: bus_req_o<=0, state->DONE, bus_err_o<=1 (sticky until rst).
  - An aborted load writes wb_data_o=ERR_DATA with RegWrite_o=1; an aborted store writes nothing.
  - Ack and timeout in the same cycle: ack wins.
- Undefined: no counter; ACCESS waits indefinitely; bus_err_o tied 0.

Test Plan:
1. Reset during ACCESS with bus_req_o=1 -> bus_req_o, stall_o, RegWrite_o all 0 immediately; state IDLE.
2. Back-to-back ALU ops (result_i=5 then 9, ALUToReg_i=1, dst=3/4) -> wb_data_o 5 then 9 on consecutive cycles, RegWrite_o=1, stall_o=0 throughout.
3. Load addr 0x40, ack with rdata 0x1234 in first ACCESS cycle -> bus_addr_o=0x40, bus_we_o=0; stall_o high 2 cycles; wb_data_o=0x1234, RegWrite_o=1 exactly one cycle.
4. Store addr 0x10 data 0xAA, ack after 3 wait cycles -> bus_we_o=1, bus_wdata_o=0xAA held 4 cycles; stall_o high 5 cycles; RegWrite_o never 1.
5. Load immediately followed by ALU op (result 7) -> ALU result appears exactly one bubble after the load write-back; no duplicate load write.
6. MEM_TIMEOUT_EN, TIMEOUT=4, load with no ack -> req drops after 4 ACCESS cycles; bus_err_o=1 and stays; wb_data_o=0xDEADBEEF.
